// File: rtl/tvline_tag.sv
// Transmit-side line tagger: frames active video from de/vsync timing and
// writes each accepted pixel to the TX FIFO as {y, x, pix}.
module tvline_tag #(
    parameter int unsigned MAX_PIX   = 1280,
    parameter int unsigned MAX_LINES = 720
) (
    input  logic        clk74m_i,
    input  logic        restart_ni,
    input  logic        vid_de_i,
    input  logic        vid_vsync_i,
    input  logic [23:0] vid_pix_i,
    input  logic        fifo_full_i,
    output logic        fifo_wr_en_o,
    output logic [45:0] fifo_din_o,
    output logic        locked_o,
    output logic        line_done_o,
    output logic        frame_done_o,
    output logic [10:0] y_cnt_o,
    output logic        ovf_o,
    output logic        len_err_o,
    output logic [15:0] drop_cnt_o
);

    localparam logic [10:0] MaxPixW   = 11'(MAX_PIX);
    localparam logic [10:0] MaxLinesW = 11'(MAX_LINES);

    typedef enum logic [1:0] {
        StUnlocked,
        StVblank,
        StActive,
        StHblank
    } state_e;

    // Input stage (S1) plus one-cycle history for edge detection.
    logic        de_q, vs_q, de_prev_q, vs_prev_q;
    logic [23:0] pix_q;

    state_e      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        wr_q, wr_d;
    logic [45:0] din_q, din_d;
    logic        locked_q, locked_d;
    logic        line_done_q, line_done_d;
    logic        frame_done_q, frame_done_d;
    logic        ovf_q, ovf_d;
    logic        len_err_q, len_err_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic de_rise, vs_rise, take_pix;

    assign de_rise = de_q & ~de_prev_q;
    assign vs_rise = vs_q & ~vs_prev_q;

    // Register the decoder outputs once and keep their previous values.
    always_ff @(posedge clk74m_i or negedge restart_ni) begin
        if (!restart_ni) begin
            de_q      <= 1'b0;
            vs_q      <= 1'b0;
            pix_q     <= '0;
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            de_q      <= vid_de_i;
            vs_q      <= vid_vsync_i;
            pix_q     <= vid_pix_i;
            de_prev_q <= de_q;
            vs_prev_q <= vs_q;
        end
    end

    // Framing FSM, pixel acceptance and status next-state.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        wr_d         = 1'b0;
        din_d        = din_q;
        locked_d     = locked_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        ovf_d        = ovf_q;
        len_err_d    = len_err_q;
        drop_cnt_d   = drop_cnt_q;
        take_pix     = 1'b0;

        case (state_q)
            StUnlocked: begin
                if (vs_rise) begin
                    state_d  = StVblank;
                    locked_d = 1'b1;
                    x_d      = '0;
                    y_d      = '0;
                end
            end
            StVblank: begin
                if (de_rise) begin
                    state_d  = StActive;
                    take_pix = 1'b1;
                end
            end
            StActive: begin
                if (de_q) begin
                    take_pix = 1'b1;
                end else begin
                    state_d     = StHblank;
                    line_done_d = 1'b1;
                    y_d         = y_q + 11'd1;
                    x_d         = '0;
                end
            end
            StHblank: begin
                if (de_rise) begin
                    // Lines past the frame limit are swallowed whole; y holds.
                    if (y_q >= MaxLinesW) begin
                        len_err_d = 1'b1;
                    end else begin
                        state_d  = StActive;
                        take_pix = 1'b1;
                    end
                end
            end
            default: state_d = StUnlocked;
        endcase

        // A vsync edge overrides everything else once locked, including a
        // coincident de fall, so the partial line is aborted without line_done.
        if (state_q != StUnlocked && vs_rise) begin
            state_d      = StVblank;
            x_d          = '0;
            y_d          = '0;
            take_pix     = 1'b0;
            line_done_d  = 1'b0;
            frame_done_d = (y_q != 11'd0);
            if (state_q == StActive) begin
                len_err_d = 1'b1;
            end
        end

        if (take_pix) begin
            if (x_q >= MaxPixW) begin
                len_err_d = 1'b1;
            end else begin
                // x advances even on a dropped pixel so later columns stay right.
                x_d = x_q + 11'd1;
                if (fifo_full_i) begin
                    ovf_d = 1'b1;
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end else begin
                    wr_d  = 1'b1;
                    din_d = {y_q, x_q, pix_q};
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk74m_i or negedge restart_ni) begin
        if (!restart_ni) begin
            state_q      <= StUnlocked;
            x_q          <= '0;
            y_q          <= '0;
            wr_q         <= 1'b0;
            din_q        <= '0;
            locked_q     <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            len_err_q    <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            wr_q         <= wr_d;
            din_q        <= din_d;
            locked_q     <= locked_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
            len_err_q    <= len_err_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign fifo_wr_en_o = wr_q;
    assign fifo_din_o   = din_q;
    assign locked_o     = locked_q;
    assign line_done_o  = line_done_q;
    assign frame_done_o = frame_done_q;
    assign y_cnt_o      = y_q;
    assign ovf_o        = ovf_q;
    assign len_err_o    = len_err_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_tvline_tag.sv
// Bench for tvline_tag: line/frame-level reference model with a write scoreboard.
module tb_tvline_tag;

    localparam int MaxPix   = 8;
    localparam int MaxLines = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        de       = 1'b0;
    logic        vs       = 1'b0;
    logic [23:0] pix      = '0;
    logic        full     = 1'b0;
    logic        wr_en;
    logic [45:0] din;
    logic        locked;
    logic        line_done;
    logic        frame_done;
    logic [10:0] y_cnt;
    logic        ovf;
    logic        len_err;
    logic [15:0] drop_cnt;

    tvline_tag #(
        .MAX_PIX  (MaxPix),
        .MAX_LINES(MaxLines)
    ) dut (
        .clk74m_i    (clk),
        .restart_ni  (rst_n),
        .vid_de_i    (de),
        .vid_vsync_i (vs),
        .vid_pix_i   (pix),
        .fifo_full_i (full),
        .fifo_wr_en_o(wr_en),
        .fifo_din_o  (din),
        .locked_o    (locked),
        .line_done_o (line_done),
        .frame_done_o(frame_done),
        .y_cnt_o     (y_cnt),
        .ovf_o       (ovf),
        .len_err_o   (len_err),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int obs_ld = 0, obs_fd = 0, obs_wr = 0;
    bit lat_seen = 1'b0;
    int lat_cyc = 0, lat_start = 0, line_start_cyc = 0;
    logic drop_pend = 1'b0;

    // Reference model state: expected writes and expected status.
    logic [45:0] exp_q[$];
    bit m_locked = 1'b0, m_ovf = 1'b0, m_len_err = 1'b0;
    int m_line = 0, m_ld = 0, m_fd = 0, m_drops = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, want);
        end
    endtask

    // Scoreboard: every write must match the next expected tagged pixel.
    always @(negedge clk) begin
        logic [45:0] w;
        if (line_done) obs_ld++;
        if (frame_done) obs_fd++;
        if (wr_en) begin
            obs_wr++;
            if (!lat_seen) begin
                lat_seen = 1'b1;
                lat_cyc  = cyc;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(wr_en), 64'(0));
            end else begin
                w = exp_q.pop_front();
                check("fifo_din", 64'(din), 64'(w));
            end
        end
    end

    // fifo_full is seen by the DUT one cycle after the pixel it applies to.
    task automatic step(input logic s_de, input logic s_vs, input logic [23:0] s_pix,
                        input logic s_drop);
        @(posedge clk);
        #1;
        de        = s_de;
        vs        = s_vs;
        pix       = s_pix;
        full      = drop_pend;
        drop_pend = s_drop;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 24'd0, 1'b0);
    endtask

    task automatic vsync_pulse();
        if (m_locked && m_line > 0) m_fd++;
        m_locked = 1'b1;
        m_line   = 0;
        step(1'b0, 1'b1, 24'd0, 1'b0);
        step(1'b0, 1'b1, 24'd0, 1'b0);
        idle(2);
    endtask

    // abort: 0 normal end, 1 vsync rises while de still high, 2 vsync with de fall.
    task automatic send_line(input int npix, input logic [15:0] mask, input int abort);
        logic [23:0] p;
        bit taken;
        taken = m_locked && (m_line < MaxLines);
        if (m_locked && !taken) m_len_err = 1'b1;
        for (int i = 0; i < npix; i++) begin
            p = 24'($urandom);
            step(1'b1, 1'b0, p, mask[i]);
            if (i == 0) line_start_cyc = cyc;
            if (taken) begin
                if (i >= MaxPix) begin
                    m_len_err = 1'b1;
                end else if (mask[i]) begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end else begin
                    exp_q.push_back({11'(m_line), 11'(i), p});
                end
            end
        end
        if (abort == 0) begin
            step(1'b0, 1'b0, 24'd0, 1'b0);
            if (taken) begin
                m_ld++;
                m_line++;
            end
        end else begin
            if (abort == 1) step(1'b1, 1'b1, 24'($urandom), 1'b0);
            else step(1'b0, 1'b1, 24'd0, 1'b0);
            step(1'b0, 1'b1, 24'd0, 1'b0);
            step(1'b0, 1'b0, 24'd0, 1'b0);
            if (taken) m_len_err = 1'b1;
            if (m_locked && m_line > 0) m_fd++;
            m_locked = 1'b1;
            m_line   = 0;
        end
        idle(2);
    endtask

    task automatic checkpoint(input string tag);
        idle(5);
        check({tag, "_drained"},    64'(exp_q.size()), 64'(0));
        check({tag, "_line_done"},  64'(obs_ld),       64'(m_ld));
        check({tag, "_frame_done"}, 64'(obs_fd),       64'(m_fd));
        check({tag, "_y_cnt"},      64'(y_cnt),        64'(m_line));
        check({tag, "_locked"},     64'(locked),       64'(m_locked));
        check({tag, "_ovf"},        64'(ovf),          64'(m_ovf));
        check({tag, "_len_err"},    64'(len_err),      64'(m_len_err));
        check({tag, "_drop_cnt"},   64'(drop_cnt),     64'(m_drops));
    endtask

    // Asynchronous reset: outputs must clear without a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_wr_en",      64'(wr_en),      64'(0));
        check("rst_din",        64'(din),        64'(0));
        check("rst_locked",     64'(locked),     64'(0));
        check("rst_line_done",  64'(line_done),  64'(0));
        check("rst_frame_done", 64'(frame_done), 64'(0));
        check("rst_y_cnt",      64'(y_cnt),      64'(0));
        check("rst_ovf",        64'(ovf),        64'(0));
        check("rst_len_err",    64'(len_err),    64'(0));
        check("rst_drop_cnt",   64'(drop_cnt),   64'(0));
        exp_q.delete();
        m_locked  = 1'b0;
        m_ovf     = 1'b0;
        m_len_err = 1'b0;
        m_line    = 0;
        m_drops   = 0;
        drop_pend = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int nl;
        int np;
        int ab;
        logic [15:0] mk;

        do_reset();

        // de activity before any vsync produces nothing.
        send_line(8, 16'h0, 0);
        send_line(8, 16'h0, 0);
        checkpoint("unlocked");
        check("unlocked_writes", 64'(obs_wr), 64'(0));

        // Three clean frames of 4 x 8.
        vsync_pulse();
        for (int f = 0; f < 3; f++) begin
            for (int l = 0; l < 4; l++) begin
                send_line(8, 16'h0, 0);
                if (f == 0 && l == 0) lat_start = line_start_cyc;
            end
            if (f < 2) vsync_pulse();
        end
        checkpoint("frames");
        check("frames_writes", 64'(obs_wr), 64'(96));
        check("first_write_seen", 64'(lat_seen), 64'(1));
        check("first_write_latency", 64'(lat_cyc - lat_start), 64'(2));

        // fifo_full for three consecutive pixels mid-line.
        do_reset();
        vsync_pulse();
        send_line(8, 16'b0000_0000_0011_1000, 0);
        send_line(8, 16'h0, 0);
        checkpoint("fifo_full");

        // Over-long lines: columns past MAX_PIX dropped.
        do_reset();
        vsync_pulse();
        send_line(10, 16'h0, 0);
        send_line(10, 16'h0, 0);
        checkpoint("long_line");

        // Too many lines: only y 0..3 written.
        do_reset();
        vsync_pulse();
        for (int l = 0; l < 6; l++) send_line(8, 16'h0, 0);
        checkpoint("many_lines");
        vsync_pulse();
        send_line(4, 16'h0, 0);
        checkpoint("many_lines_next");

        // Aborts: vsync during de, then vsync coincident with de fall.
        do_reset();
        vsync_pulse();
        send_line(3, 16'h0, 1);
        send_line(5, 16'h0, 0);
        checkpoint("abort_de_high");
        send_line(8, 16'h0, 0);
        send_line(4, 16'h0, 2);
        send_line(2, 16'h0, 0);
        checkpoint("abort_de_fall");

        // Randomized frames with drops and aborts.
        do_reset();
        vsync_pulse();
        for (int f = 0; f < 5; f++) begin
            nl = $urandom_range(1, 6);
            for (int l = 0; l < nl; l++) begin
                np = $urandom_range(1, 10);
                mk = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
                ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
                send_line(np, mk, ab);
            end
            vsync_pulse();
        end
        checkpoint("random");

        // Reset in the middle of a line, then relock.
        vsync_pulse();
        for (int i = 0; i < 5; i++) begin
            logic [23:0] p;
            p = 24'($urandom);
            step(1'b1, 1'b0, p, 1'b0);
            exp_q.push_back({11'd0, 11'(i), p});
        end
        do_reset();
        send_line(4, 16'h0, 0);
        checkpoint("restart_unlocked");
        vsync_pulse();
        send_line(8, 16'h0, 0);
        checkpoint("restart_relock");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
